// File: rtl/lvds_lane_dispatcher_if.sv
// Byte-stream handshake between the framing logic and the LVDS lane dispatcher.
interface lvds_lane_dispatcher_if;
    logic [7:0] s_data;
    logic       s_sof;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_sof, output s_valid, input s_ready);
    modport slave  (input s_data, input s_sof, input s_valid, output s_ready);
endinterface

// File: rtl/lvds_lane_dispatcher.sv
// Stripes an incoming byte stream round-robin across the serializer lanes, one start pulse per byte.
// Optional build macro DISPATCH_STAT_EN adds the frame_cnt/byte_cnt statistics outputs.
module lvds_lane_dispatcher #(
    parameter int NUM_LANES = 23,
    parameter int BUSY_TO   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    lvds_lane_dispatcher_if.slave  s,
    input  logic [NUM_LANES-1:0]   lane_busy_i,
    output logic [NUM_LANES*8-1:0] data_o,
    output logic [NUM_LANES-1:0]   start_o,
    output logic [NUM_LANES-1:0]   st_flag_o,
    output logic [NUM_LANES-1:0]   err_timeout,
    output logic                   idle_o
`ifdef DISPATCH_STAT_EN
    ,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            byte_cnt
`endif
);

    localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [PW-1:0] LAST_LANE = PW'(NUM_LANES - 1);
    localparam logic [3:0]    TO_LAST   = 4'(BUSY_TO - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_BUSY   = 2'd3
    } lane_state_t;

    lane_state_t           state_r [NUM_LANES];
    logic [3:0]            cnt_r   [NUM_LANES];
    logic [PW-1:0]         ptr_r;
    logic [PW-1:0]         tgt_s;
    logic                  ready_s;
    logic                  accept_s;
    logic [NUM_LANES-1:0]  lane_idle_s;

    // Target lane selection and readiness; a start-of-frame byte always restarts at lane 0
    always_comb begin
        tgt_s   = s.s_sof ? {PW{1'b0}} : ptr_r;
        ready_s = 1'b0;
        if (!reset && (state_r[tgt_s] == ST_IDLE) && !lane_busy_i[tgt_s]) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign s.s_ready = ready_s;
    assign accept_s  = s.s_valid & ready_s;

    // Per-lane idle flags feeding the registered idle_o
    always_comb begin
        lane_idle_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_idle_s[i] = (state_r[i] == ST_IDLE);
        end
    end

    // Stripe pointer, per-lane launch/handshake FSMs and their registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r       <= {PW{1'b0}};
            data_o      <= '0;
            start_o     <= '0;
            st_flag_o   <= '0;
            err_timeout <= '0;
            idle_o      <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= 4'd0;
            end
        end else begin
            if (accept_s) begin
                ptr_r <= (tgt_s == LAST_LANE) ? {PW{1'b0}} : tgt_s + PW'(1);
            end
            idle_o <= (&lane_idle_s) & ~(|lane_busy_i);
            for (int i = 0; i < NUM_LANES; i++) begin
                case (state_r[i])
                    ST_IDLE: begin
                        if (accept_s && (tgt_s == PW'(i))) begin
                            data_o[8*i +: 8] <= s.s_data;
                            st_flag_o[i]     <= s.s_sof;
                            start_o[i]       <= 1'b1;
                            state_r[i]       <= ST_LAUNCH;
                        end else begin
                            start_o[i] <= 1'b0;
                        end
                    end
                    ST_LAUNCH: begin
                        start_o[i]   <= 1'b0;
                        st_flag_o[i] <= 1'b0;
                        cnt_r[i]     <= 4'd0;
                        state_r[i]   <= ST_WAIT;
                    end
                    // Busy takes priority over the timeout boundary
                    ST_WAIT: begin
                        if (lane_busy_i[i]) begin
                            state_r[i] <= ST_BUSY;
                        end else if ((cnt_r[i] + 4'd1) == TO_LAST) begin
                            err_timeout[i] <= 1'b1;
                            state_r[i]     <= ST_IDLE;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + 4'd1;
                        end
                    end
                    ST_BUSY: begin
                        if (!lane_busy_i[i]) begin
                            state_r[i] <= ST_IDLE;
                        end
                    end
                    default: begin
                        start_o[i] <= 1'b0;
                        state_r[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DISPATCH_STAT_EN
    // Accepted-byte and frame statistics, wrapping at 16 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= 16'd0;
            byte_cnt  <= 16'd0;
        end else if (accept_s) begin
            byte_cnt <= byte_cnt + 16'd1;
            if (s.s_sof) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lvds_lane_dispatcher.sv
// Self-checking bench for lvds_lane_dispatcher: directed scenarios plus a randomized run against a timing model.
module tb_lvds_lane_dispatcher;
    localparam int NL = 23;
    localparam int BT = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NL-1:0]       lane_busy;
    logic [NL*8-1:0]     data_o;
    logic [NL-1:0]       start_o, st_flag_o, err_timeout;
    logic                idle_o;
`ifdef DISPATCH_STAT_EN
    logic [15:0]         frame_cnt, byte_cnt;
`endif

    lvds_lane_dispatcher_if sif();

    lvds_lane_dispatcher #(.NUM_LANES(NL), .BUSY_TO(BT)) dut (
        .clk(clk), .reset(reset), .s(sif), .lane_busy_i(lane_busy),
        .data_o(data_o), .start_o(start_o), .st_flag_o(st_flag_o),
        .err_timeout(err_timeout), .idle_o(idle_o)
`ifdef DISPATCH_STAT_EN
        , .frame_cnt(frame_cnt), .byte_cnt(byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model: lane occupancy derived from accept time and observed busy
    logic [7:0]    m_data [NL];
    bit            m_occ  [NL];
    bit            m_seen [NL];
    int            m_acc  [NL];
    logic [NL-1:0] m_err, m_start, m_flag;
    int            m_ptr;
    bit            m_idle;
    int            acc_total, sof_total;
    // serializer responder: busy rises cfg_d cycles after start for cfg_len cycles (cfg_d < 0: never)
    int            cfg_d [NL];
    int            cfg_len [NL];
    int            r_wait [NL];
    int            r_left [NL];

    task automatic clear_model();
        for (int i = 0; i < NL; i++) begin
            m_data[i] = 8'd0; m_occ[i] = 1'b0; m_seen[i] = 1'b0; m_acc[i] = 0;
            r_wait[i] = 0; r_left[i] = 0;
        end
        m_err = '0; m_start = '0; m_flag = '0; m_ptr = 0; m_idle = 1'b0;
        acc_total = 0; sof_total = 0;
        lane_busy = '0;
    endtask

    task automatic set_cfg(input int d, input int len);
        for (int i = 0; i < NL; i++) begin
            cfg_d[i] = d; cfg_len[i] = len;
        end
    endtask

    task automatic do_reset();
        sif.s_valid = 1'b0; sif.s_sof = 1'b0; sif.s_data = 8'd0;
        reset = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // one clock edge: model update from the values held before the edge, then responder
    task automatic tick(output bit acc);
        int            tgt;
        logic [NL-1:0] bs;
        tgt = sif.s_sof ? 0 : m_ptr;
        acc = sif.s_valid && sif.s_ready;
        bs  = lane_busy;
        @(posedge clk);
        cyc++;
        m_idle = (bs == '0);
        for (int i = 0; i < NL; i++) begin
            if (m_occ[i]) begin
                m_idle = 1'b0;
                if (!m_seen[i] && (cyc >= m_acc[i] + 2) && bs[i]) m_seen[i] = 1'b1;
                else if (m_seen[i] && !bs[i]) m_occ[i] = 1'b0;
                else if (!m_seen[i] && (cyc == m_acc[i] + BT)) begin
                    m_occ[i] = 1'b0; m_err[i] = 1'b1;
                end
            end
        end
        m_start = '0; m_flag = '0;
        if (acc) begin
            m_data[tgt] = sif.s_data; m_start[tgt] = 1'b1; m_flag[tgt] = sif.s_sof;
            m_occ[tgt] = 1'b1; m_seen[tgt] = 1'b0; m_acc[tgt] = cyc;
            m_ptr = (tgt == NL - 1) ? 0 : tgt + 1;
            acc_total++;
            if (sif.s_sof) sof_total++;
        end
        #1;
        for (int i = 0; i < NL; i++) begin
            if (start_o[i] && cfg_d[i] >= 0) begin
                r_wait[i] = cfg_d[i]; r_left[i] = cfg_len[i];
            end
            if (r_left[i] > 0) begin
                if (r_wait[i] == 0) begin lane_busy[i] = 1'b1; r_left[i]--; end
                else begin lane_busy[i] = 1'b0; r_wait[i]--; end
            end else lane_busy[i] = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit sof, output int stalls, output bit ok);
        bit acc;
        stalls = 0; ok = 1'b0;
        sif.s_data = d; sif.s_sof = sof; sif.s_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            #1;
            tick(acc);
            if (acc) begin ok = 1'b1; break; end
            stalls++;
        end
        sif.s_valid = 1'b0; sif.s_sof = 1'b0;
    endtask

    function automatic logic [NL-1:0] onehot(input int lane);
        logic [NL-1:0] v;
        v = '0; v[lane] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        bit acc;
        sif.s_valid = 1'b0; sif.s_sof = 1'b0; sif.s_data = 8'd0;
        reset = 1'b1; clear_model(); set_cfg(-1, 0);
        @(posedge clk); #1;
        n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL rst_data got %h exp 0", data_o); end
        n_checks++; if (start_o !== '0 || st_flag_o !== '0) begin n_fail++; $display("FAIL rst_start got %h/%h exp 0", start_o, st_flag_o); end
        n_checks++; if (err_timeout !== '0) begin n_fail++; $display("FAIL rst_err got %h exp 0", err_timeout); end
        n_checks++; if (sif.s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", sif.s_ready); end
`ifdef DISPATCH_STAT_EN
        n_checks++; if (byte_cnt !== 16'd0 || frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %h/%h exp 0", byte_cnt, frame_cnt); end
`endif
        reset = 1'b0; #1;
        n_checks++; if (sif.s_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready got %b exp 1", sif.s_ready); end
        tick(acc);
        n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL rel_idle got %b exp 1", idle_o); end
        n_checks++; if (start_o !== '0 || data_o !== '0) begin n_fail++; $display("FAIL rel_out got %h/%h exp 0", start_o, data_o); end
    endtask

    task automatic test_frame();
        int stalls; bit ok; int lane;
        do_reset(); set_cfg(1, 8); cfg_len[0] = 30;
        for (int b = 0; b < 25; b++) begin
            send_byte(8'(b), b == 0, stalls, ok);
            lane = b % NL;
            n_checks++; if (!ok) begin n_fail++; $display("FAIL frame_accept byte %0d got none exp accept", b); end
            n_checks++; if (data_o[8*lane +: 8] !== 8'(b)) begin n_fail++; $display("FAIL frame_data lane %0d got %h exp %h", lane, data_o[8*lane +: 8], 8'(b)); end
            n_checks++; if (start_o !== onehot(lane)) begin n_fail++; $display("FAIL frame_start byte %0d got %h exp %h", b, start_o, onehot(lane)); end
            n_checks++; if (st_flag_o !== ((b == 0) ? onehot(0) : '0)) begin n_fail++; $display("FAIL frame_flag byte %0d got %h", b, st_flag_o); end
            if (b == 23) begin
                n_checks++; if (stalls == 0) begin n_fail++; $display("FAIL frame_stall got %0d stalls exp >0", stalls); end
            end
        end
    endtask

    task automatic test_mid_sof();
        int stalls; bit ok; bit acc;
        do_reset(); set_cfg(1, 2);
        for (int b = 0; b < 5; b++) send_byte(8'h10 + 8'(b), b == 0, stalls, ok);
        send_byte(8'hA5, 1'b1, stalls, ok);
        n_checks++; if (!ok || data_o[7:0] !== 8'hA5) begin n_fail++; $display("FAIL mid_data got %h exp a5", data_o[7:0]); end
        n_checks++; if (start_o !== onehot(0) || st_flag_o !== onehot(0)) begin n_fail++; $display("FAIL mid_start got %h/%h exp 1/1", start_o, st_flag_o); end
        tick(acc);
        n_checks++; if (start_o !== '0 || st_flag_o !== '0 || data_o[7:0] !== 8'hA5) begin n_fail++; $display("FAIL mid_pulse got %h/%h/%h", start_o, st_flag_o, data_o[7:0]); end
        send_byte(8'h5A, 1'b0, stalls, ok);
        n_checks++; if (!ok || start_o !== onehot(1) || data_o[15:8] !== 8'h5A) begin n_fail++; $display("FAIL mid_next got %h/%h exp lane1 5a", start_o, data_o[15:8]); end
    endtask

    task automatic test_timeout();
        int stalls; bit ok; bit acc; int n;
        do_reset(); set_cfg(1, 2); cfg_d[3] = -1;
        for (int b = 0; b < 4; b++) send_byte(8'(b), b == 0, stalls, ok);
        n_checks++; if (start_o !== onehot(3)) begin n_fail++; $display("FAIL to_start got %h exp %h", start_o, onehot(3)); end
        n = 0;
        while (!err_timeout[3] && n < 20) begin tick(acc); n++; end
        n_checks++; if (n != BT) begin n_fail++; $display("FAIL to_delay got %0d exp %0d", n, BT); end
        n_checks++; if (err_timeout !== onehot(3)) begin n_fail++; $display("FAIL to_err got %h exp %h", err_timeout, onehot(3)); end
        for (int b = 0; b < 4; b++) send_byte(8'h30 + 8'(b), b == 0, stalls, ok);
        n_checks++; if (!ok || start_o !== onehot(3) || data_o[31:24] !== 8'h33) begin n_fail++; $display("FAIL to_reuse got %h/%h", start_o, data_o[31:24]); end
        n_checks++; if (err_timeout !== onehot(3)) begin n_fail++; $display("FAIL to_sticky got %h exp %h", err_timeout, onehot(3)); end
    endtask

    task automatic test_busy_last();
        int stalls; bit ok; bit acc; int bad;
        do_reset(); set_cfg(BT - 1, 3);
        send_byte(8'h42, 1'b1, stalls, ok);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick(acc);
            if (err_timeout !== '0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL busy_last got err %h exp 0", err_timeout); end
        n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL busy_last_idle got %b exp 1", idle_o); end
    endtask

    task automatic test_reset_mid();
        int stalls; bit ok; bit acc;
        do_reset(); set_cfg(0, 40);
        for (int b = 0; b < 9; b++) send_byte(8'h80 + 8'(b), b == 0, stalls, ok);
        repeat (3) tick(acc);
        send_byte(8'h89, 1'b0, stalls, ok);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (data_o !== '0 || start_o !== '0 || st_flag_o !== '0) begin n_fail++; $display("FAIL amid_out got %h/%h", start_o, data_o[7:0]); end
        n_checks++; if (sif.s_ready !== 1'b0) begin n_fail++; $display("FAIL amid_ready got %b exp 0", sif.s_ready); end
`ifdef DISPATCH_STAT_EN
        n_checks++; if (byte_cnt !== 16'd0 || frame_cnt !== 16'd0) begin n_fail++; $display("FAIL amid_cnt got %h/%h exp 0", byte_cnt, frame_cnt); end
`endif
        clear_model();
        @(posedge clk); #1 reset = 1'b0;
        send_byte(8'h77, 1'b0, stalls, ok);
        n_checks++; if (!ok || start_o !== onehot(0) || data_o[7:0] !== 8'h77) begin n_fail++; $display("FAIL amid_ptr got %h/%h exp lane0 77", start_o, data_o[7:0]); end
    endtask

    task automatic test_random();
        bit acc; int t; bit pred; logic [NL*8-1:0] ed; int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 900; c++) begin
            if (c % 150 == 0) begin
                for (int i = 0; i < NL; i++) begin
                    cfg_d[i]   = $urandom_range(0, BT);
                    if (cfg_d[i] == BT) cfg_d[i] = -1;
                    cfg_len[i] = $urandom_range(1, 6);
                end
            end
            sif.s_valid = ($urandom_range(0, 3) != 0);
            sif.s_sof   = ($urandom_range(0, 9) == 0);
            sif.s_data  = 8'($urandom);
            #1;
            t = sif.s_sof ? 0 : m_ptr;
            pred = !m_occ[t] && !lane_busy[t];
            n_checks++; if (sif.s_ready !== pred) begin n_fail++; if (bad++ < 10) $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, sif.s_ready, pred); end
            tick(acc);
            for (int i = 0; i < NL; i++) ed[8*i +: 8] = m_data[i];
            n_checks++; if (data_o !== ed) begin n_fail++; if (bad++ < 10) $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, data_o, ed); end
            n_checks++; if (start_o !== m_start || st_flag_o !== m_flag) begin n_fail++; if (bad++ < 10) $display("FAIL rnd_start cyc %0d got %h/%h exp %h/%h", cyc, start_o, st_flag_o, m_start, m_flag); end
            n_checks++; if (err_timeout !== m_err) begin n_fail++; if (bad++ < 10) $display("FAIL rnd_err cyc %0d got %h exp %h", cyc, err_timeout, m_err); end
            n_checks++; if (idle_o !== m_idle) begin n_fail++; if (bad++ < 10) $display("FAIL rnd_idle cyc %0d got %b exp %b", cyc, idle_o, m_idle); end
        end
        sif.s_valid = 1'b0;
    endtask

`ifdef DISPATCH_STAT_EN
    task automatic test_stats();
        int stalls; bit ok;
        do_reset(); set_cfg(-1, 0);
        for (int i = 0; i < 65536; i++) begin
            send_byte(8'(i), (i % 50) == 0, stalls, ok);
            if (i == 999) begin
                n_checks++; if (byte_cnt !== 16'd1000 || frame_cnt !== 16'd20) begin n_fail++; $display("FAIL stat_mid got %0d/%0d exp 1000/20", byte_cnt, frame_cnt); end
            end
        end
        n_checks++; if (acc_total != 65536 || byte_cnt !== 16'd0) begin n_fail++; $display("FAIL stat_wrap got %0d after %0d exp 0", byte_cnt, acc_total); end
        n_checks++; if (frame_cnt !== 16'(sof_total)) begin n_fail++; $display("FAIL stat_frames got %0d exp %0d", frame_cnt, sof_total); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        lane_busy = '0;
        sif.s_valid = 1'b0; sif.s_sof = 1'b0; sif.s_data = 8'd0;
        test_reset();
        test_frame();
        test_mid_sof();
        test_timeout();
        test_busy_last();
        test_reset_mid();
        test_random();
`ifdef DISPATCH_STAT_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
